// File: rtl/mips_mc.sv
// mips_mc: multi-cycle core for the 16-bit MIPS-like ISA with req/ready instruction and data ports.
// Define MIPS_MC_PERF_CNT_EN to build the cycle/instret counters; otherwise they read 0.
module mips_mc #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned PC_W     = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ready,
  input  logic [15:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [PC_W-1:0]   pc_out,
  output logic [DATA_W-1:0] alu_result,
  output logic              retire,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       instret_cnt
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [2:0] OP_R    = 3'd0;
  localparam logic [2:0] OP_SLTI = 3'd1;
  localparam logic [2:0] OP_J    = 3'd2;
  localparam logic [2:0] OP_JAL  = 3'd3;
  localparam logic [2:0] OP_LW   = 3'd4;
  localparam logic [2:0] OP_SW   = 3'd5;
  localparam logic [2:0] OP_BEQ  = 3'd6;
  localparam logic [2:0] OP_ADDI = 3'd7;

  localparam logic [31:0] RESET_PC_V = 32'(RESET_PC);

  logic [2:0]        r_state;
  logic [PC_W-1:0]   r_pc;
  logic [15:0]       r_ir;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_alu;
  logic [DATA_W-1:0] r_mdr;
  logic [DATA_W-1:0] r_rf [8];

  logic [2:0]        w_op, w_rs, w_rt, w_rd;
  logic [3:0]        w_funct;
  logic [12:0]       w_jt;
  logic [DATA_W-1:0] w_imm;
  logic [PC_W-1:0]   w_boff, w_pc2, w_pcbr, w_jpc, w_jr_pc, w_npc;
  logic [DATA_W-1:0] w_link;
  logic [DATA_W-1:0] w_alu;
  logic              w_r_alu, w_ctrl;
  logic              w_we;
  logic [2:0]        w_waddr;
  logic [DATA_W-1:0] w_wdata;

  assign w_op    = r_ir[15:13];
  assign w_rs    = r_ir[12:10];
  assign w_rt    = r_ir[9:7];
  assign w_rd    = r_ir[6:4];
  assign w_funct = r_ir[3:0];
  assign w_jt    = r_ir[12:0];
  assign w_imm   = {{(DATA_W-7){r_ir[6]}}, r_ir[6:0]};
  assign w_boff  = {{(PC_W-8){r_ir[6]}}, r_ir[6:0], 1'b0};
  assign w_pc2   = r_pc + PC_W'(2);
  assign w_pcbr  = w_pc2 + w_boff;

  // Jump region keeps the pc+2 bits above the 14-bit in-region offset.
  if (PC_W > 14) begin : g_jpc_hi
    assign w_jpc = {w_pc2[PC_W-1:14], w_jt, 1'b0};
  end else begin : g_jpc_lo
    assign w_jpc = {w_jt, 1'b0};
  end

  if (DATA_W >= PC_W) begin : g_jr_trunc
    assign w_jr_pc = r_a[PC_W-1:0];
  end else begin : g_jr_zext
    assign w_jr_pc = {{(PC_W-DATA_W){1'b0}}, r_a};
  end

  if (PC_W >= DATA_W) begin : g_link_trunc
    assign w_link = w_pc2[DATA_W-1:0];
  end else begin : g_link_zext
    assign w_link = {{(DATA_W-PC_W){1'b0}}, w_pc2};
  end

  // R-type functs 0..4 go through WB; jr and undefined functs finish in EXEC.
  assign w_r_alu = (w_funct <= 4'd4);
  assign w_ctrl  = (w_op == OP_BEQ) || (w_op == OP_J) || (w_op == OP_JAL) ||
                   ((w_op == OP_R) && !w_r_alu);

  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_R: begin
        case (w_funct)
          4'd0:    w_alu = r_a + r_b;
          4'd1:    w_alu = r_a - r_b;
          4'd2:    w_alu = r_a & r_b;
          4'd3:    w_alu = r_a | r_b;
          4'd4:    w_alu = {{(DATA_W-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
          default: w_alu = '0;
        endcase
      end
      OP_SLTI: w_alu = {{(DATA_W-1){1'b0}}, ($signed(r_a) < $signed(w_imm))};
      OP_BEQ:  w_alu = r_a - r_b;
      OP_LW, OP_SW, OP_ADDI: w_alu = r_a + w_imm;
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_npc = w_pc2;
    case (w_op)
      OP_BEQ:       w_npc = (r_a == r_b) ? w_pcbr : w_pc2;
      OP_J, OP_JAL: w_npc = w_jpc;
      OP_R:         w_npc = (w_funct == 4'd8) ? w_jr_pc : w_pc2;
      default:      w_npc = w_pc2;
    endcase
  end

  always_comb begin
    w_we    = 1'b0;
    w_waddr = w_rt;
    w_wdata = r_alu;
    if ((r_state == S_EXEC) && (w_op == OP_JAL)) begin
      w_we    = 1'b1;
      w_waddr = 3'd7;
      w_wdata = w_link;
    end else if (r_state == S_WB) begin
      w_we = 1'b1;
      if (w_op == OP_R) begin
        w_waddr = w_rd;
      end else if (w_op == OP_LW) begin
        w_wdata = r_mdr;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin
        r_rf[i] <= '0;
      end
    end else if (w_we && (w_waddr != 3'd0)) begin
      r_rf[w_waddr] <= w_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC_V[PC_W-1:0];
      r_ir    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_alu   <= '0;
      r_mdr   <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ready) begin
            r_ir    <= imem_rdata;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_a     <= r_rf[w_rs];
          r_b     <= r_rf[w_rt];
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_alu <= w_alu;
          if (w_ctrl) begin
            r_pc    <= w_npc;
            r_state <= S_FETCH;
          end else if ((w_op == OP_LW) || (w_op == OP_SW)) begin
            r_state <= S_MEM;
          end else begin
            r_state <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ready) begin
            if (w_op == OP_SW) begin
              r_pc    <= w_pc2;
              r_state <= S_FETCH;
            end else begin
              r_mdr   <= dmem_rdata;
              r_state <= S_WB;
            end
          end
        end
        S_WB: begin
          r_pc    <= w_pc2;
          r_state <= S_FETCH;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Gating with reset_n keeps the fetch request low while reset is held.
  assign imem_req   = reset_n && (r_state == S_FETCH);
  assign imem_addr  = r_pc;
  assign pc_out     = r_pc;
  assign dmem_req   = (r_state == S_MEM);
  assign dmem_we    = (r_state == S_MEM) && (w_op == OP_SW);
  assign dmem_addr  = r_alu;
  assign dmem_wdata = r_b;
  assign alu_result = r_alu;
  assign retire     = ((r_state == S_EXEC) && w_ctrl) ||
                      ((r_state == S_MEM) && (w_op == OP_SW) && dmem_ready) ||
                      (r_state == S_WB);

`ifdef MIPS_MC_PERF_CNT_EN
  logic [31:0] r_cycle;
  logic [31:0] r_instret;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cycle   <= '0;
      r_instret <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (retire) begin
        r_instret <= r_instret + 32'd1;
      end
    end
  end

  assign cycle_cnt   = r_cycle;
  assign instret_cnt = r_instret;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_mips_mc.sv
// Scoreboard bench for mips_mc: a 16-bit instance with wait-state memories and a 32-bit/14-bit-pc
// instance with zero-wait memories; retire and store monitors pop expectations queued up front.
module tb_mips_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, rst32_n;

  logic        i16_req, i16_rdy, d16_req, d16_we, d16_rdy, ret16;
  logic [15:0] i16_addr, i16_rdata, d16_addr, d16_wdata, d16_rdata, pc16, alu16;
  logic [31:0] cyc16, ins16;

  logic        i32_req, i32_rdy, d32_req, d32_we, d32_rdy, ret32;
  logic [13:0] i32_addr, pc32;
  logic [15:0] i32_rdata;
  logic [31:0] d32_addr, d32_wdata, d32_rdata, alu32, cyc32, ins32;

  mips_mc #(.DATA_W(16), .PC_W(16), .RESET_PC(0)) u_dut16 (
    .clk(clk), .reset_n(reset_n),
    .imem_req(i16_req), .imem_addr(i16_addr), .imem_ready(i16_rdy), .imem_rdata(i16_rdata),
    .dmem_req(d16_req), .dmem_we(d16_we), .dmem_addr(d16_addr), .dmem_wdata(d16_wdata),
    .dmem_ready(d16_rdy), .dmem_rdata(d16_rdata), .pc_out(pc16), .alu_result(alu16),
    .retire(ret16), .cycle_cnt(cyc16), .instret_cnt(ins16)
  );

  mips_mc #(.DATA_W(32), .PC_W(14), .RESET_PC(0)) u_dut32 (
    .clk(clk), .reset_n(rst32_n),
    .imem_req(i32_req), .imem_addr(i32_addr), .imem_ready(i32_rdy), .imem_rdata(i32_rdata),
    .dmem_req(d32_req), .dmem_we(d32_we), .dmem_addr(d32_addr), .dmem_wdata(d32_wdata),
    .dmem_ready(d32_rdy), .dmem_rdata(d32_rdata), .pc_out(pc32), .alu_result(alu32),
    .retire(ret32), .cycle_cnt(cyc32), .instret_cnt(ins32)
  );

  logic [15:0] imem16 [128];
  logic [15:0] dmem16 [256];
  logic [15:0] imem32 [128];
  int          iw_cnt = 0;
  int          dw_cnt = 0;

  function automatic int f_iwait(input logic [15:0] a);
    return (a == 16'h002E) ? 2 : 0;
  endfunction

  function automatic int f_dwait(input logic [15:0] a);
    if (a == 16'h0004) return 3;
    if (a == 16'h0006) return 20;
    return 0;
  endfunction

  assign i16_rdy   = i16_req && (iw_cnt >= f_iwait(i16_addr));
  assign d16_rdy   = d16_req && (dw_cnt >= f_dwait(d16_addr));
  assign i16_rdata = imem16[i16_addr[7:1]];
  assign d16_rdata = dmem16[d16_addr[7:0]];
  assign i32_rdy   = i32_req;
  assign d32_rdy   = d32_req;
  assign i32_rdata = imem32[i32_addr[7:1]];
  assign d32_rdata = '0;

  always @(posedge clk) begin
    iw_cnt <= (i16_req && !i16_rdy) ? iw_cnt + 1 : 0;
    dw_cnt <= (d16_req && !d16_rdy) ? dw_cnt + 1 : 0;
  end

  int tcyc = 0;
  int t0 = 0;
  always @(posedge clk) tcyc <= tcyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic [31:0] alu;
    bit          chk_alu;
    int          ins;
  } ret_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } st_t;

  ret_t q16[$];
  ret_t q32[$];
  st_t  qst[$];
  int   n_extra16 = 0;
  int   n_extra_st = 0;

  task automatic push16(input int cyc, input logic [31:0] pc, input logic [31:0] alu,
                        input bit ca, input int ins);
    ret_t e;
    e.cyc = cyc; e.pc = pc; e.alu = alu; e.chk_alu = ca; e.ins = ins;
    q16.push_back(e);
  endtask

  task automatic push32(input int cyc, input logic [31:0] pc, input logic [31:0] alu,
                        input bit ca, input int ins);
    ret_t e;
    e.cyc = cyc; e.pc = pc; e.alu = alu; e.chk_alu = ca; e.ins = ins;
    q32.push_back(e);
  endtask

  task automatic push_st(input logic [15:0] a, input logic [15:0] d);
    st_t s;
    s.addr = a; s.data = d;
    qst.push_back(s);
  endtask

  function automatic logic [15:0] f_i(input logic [2:0] op, input logic [2:0] rs,
                                      input logic [2:0] rt, input logic [6:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [15:0] f_r(input logic [2:0] rs, input logic [2:0] rt,
                                      input logic [2:0] rd, input logic [3:0] fn);
    return {3'b000, rs, rt, rd, fn};
  endfunction

  function automatic logic [15:0] f_j(input logic [2:0] op, input logic [12:0] t);
    return {op, t};
  endfunction

  // Retire monitor, 16-bit instance
  always @(negedge clk) begin : mon16
    ret_t e;
    if (reset_n && ret16) begin
      if (q16.size() == 0) begin
        n_extra16++;
      end else begin
        e = q16.pop_front();
        chk("ret16_cycle", 32'(tcyc - t0 + 1), 32'(e.cyc));
        chk("ret16_pc", 32'(pc16), e.pc);
        if (e.chk_alu) chk("ret16_alu", 32'(alu16), e.alu);
`ifdef MIPS_MC_PERF_CNT_EN
        chk("ret16_instret", ins16, 32'(e.ins));
        chk("ret16_cycle_cnt", cyc16, 32'(e.cyc - 1));
`else
        chk("ret16_instret_off", ins16, 32'd0);
        chk("ret16_cycle_cnt_off", cyc16, 32'd0);
`endif
      end
    end
  end

  // Retire monitor, 32-bit instance; retires after the queued program drains are not checked
  always @(negedge clk) begin : mon32
    ret_t e;
    if (rst32_n && ret32 && (q32.size() != 0)) begin
      e = q32.pop_front();
      chk("ret32_cycle", 32'(tcyc - t0 + 1), 32'(e.cyc));
      chk("ret32_pc", 32'(pc32), e.pc);
      if (e.chk_alu) chk("ret32_alu", alu32, e.alu);
`ifdef MIPS_MC_PERF_CNT_EN
      chk("ret32_instret", ins32, 32'(e.ins));
`else
      chk("ret32_instret_off", ins32, 32'd0);
`endif
    end
  end

  // Store monitor
  always @(negedge clk) begin : mon_st
    st_t s;
    if (reset_n && d16_req && d16_we && d16_rdy) begin
      if (qst.size() == 0) begin
        n_extra_st++;
      end else begin
        s = qst.pop_front();
        chk("store_addr", 32'(d16_addr), 32'(s.addr));
        chk("store_data", 32'(d16_wdata), 32'(s.data));
      end
    end
  end

  // Request-hold monitor: a pending request keeps its address until ready
  logic        hold_i = 1'b0;
  logic        hold_d = 1'b0;
  logic [15:0] hold_ia = '0;
  logic [15:0] hold_da = '0;
  always @(negedge clk) begin
    if (hold_i && reset_n) begin
      chk("imem_req_held", 32'(i16_req), 32'd1);
      chk("imem_addr_held", 32'(i16_addr), 32'(hold_ia));
    end
    if (hold_d && reset_n) begin
      chk("dmem_req_held", 32'(d16_req), 32'd1);
      chk("dmem_addr_held", 32'(d16_addr), 32'(hold_da));
    end
    hold_i  <= reset_n && i16_req && !i16_rdy;
    hold_ia <= i16_addr;
    hold_d  <= reset_n && d16_req && !d16_rdy;
    hold_da <= d16_addr;
  end

  initial begin
    bit found;
    reset_n = 1'b0;
    rst32_n = 1'b0;
    for (int i = 0; i < 128; i++) begin
      imem16[i] = '0;
      imem32[i] = '0;
    end
    for (int i = 0; i < 256; i++) dmem16[i] = '0;
    dmem16[4] = 16'hBEEF;

    imem16[8'h00 >> 1] = f_i(3'd7, 3'd0, 3'd1, 7'd5);      // addi r1,r0,5
    imem16[8'h02 >> 1] = f_i(3'd7, 3'd0, 3'd2, 7'h7D);     // addi r2,r0,-3
    imem16[8'h04 >> 1] = f_r(3'd1, 3'd2, 3'd3, 4'd0);      // add r3,r1,r2
    imem16[8'h06 >> 1] = f_i(3'd5, 3'd0, 3'd3, 7'h20);     // sw r3,0x20(r0)
    imem16[8'h08 >> 1] = f_j(3'd2, 13'h0008);              // j 0x10
    imem16[8'h10 >> 1] = f_i(3'd6, 3'd0, 3'd0, 7'd2);      // beq r0,r0,+2
    imem16[8'h16 >> 1] = f_j(3'd2, 13'h0010);              // j 0x20
    imem16[8'h20 >> 1] = f_j(3'd3, 13'h0040);              // jal 0x80
    imem16[8'h80 >> 1] = f_r(3'd7, 3'd0, 3'd0, 4'd8);      // jr r7
    imem16[8'h22 >> 1] = f_i(3'd5, 3'd0, 3'd7, 7'h30);     // sw r7,0x30(r0)
    imem16[8'h24 >> 1] = f_r(3'd2, 3'd1, 3'd4, 4'd4);      // slt r4,r2,r1
    imem16[8'h26 >> 1] = f_r(3'd1, 3'd1, 3'd1, 4'd5);      // undefined funct
    imem16[8'h28 >> 1] = f_i(3'd5, 3'd0, 3'd1, 7'h32);     // sw r1,0x32(r0)
    imem16[8'h2A >> 1] = f_i(3'd7, 3'd0, 3'd0, 7'd7);      // addi r0,r0,7
    imem16[8'h2C >> 1] = f_i(3'd5, 3'd0, 3'd0, 7'h34);     // sw r0,0x34(r0)
    imem16[8'h2E >> 1] = f_i(3'd4, 3'd0, 3'd4, 7'd4);      // lw r4,4(r0)
    imem16[8'h30 >> 1] = f_i(3'd5, 3'd0, 3'd4, 7'h36);     // sw r4,0x36(r0)
    imem16[8'h32 >> 1] = f_i(3'd5, 3'd0, 3'd1, 7'd6);      // sw r1,6(r0), reset hits here

    imem32[8'h00 >> 1] = f_i(3'd7, 3'd0, 3'd1, 7'h7F);     // addi r1,r0,-1
    imem32[8'h02 >> 1] = f_r(3'd1, 3'd1, 3'd2, 4'd0);      // add r2,r1,r1
    imem32[8'h04 >> 1] = f_r(3'd1, 3'd0, 3'd3, 4'd4);      // slt r3,r1,r0
    imem32[8'h06 >> 1] = f_r(3'd1, 3'd1, 3'd0, 4'd0);      // add r0,r1,r1
    imem32[8'h08 >> 1] = f_r(3'd0, 3'd3, 3'd5, 4'd0);      // add r5,r0,r3
    imem32[8'h0A >> 1] = f_r(3'd2, 3'd0, 3'd6, 4'd0);      // add r6,r2,r0
    imem32[8'h0C >> 1] = f_j(3'd3, 13'h0010);              // jal 0x20
    imem32[8'h20 >> 1] = f_r(3'd7, 3'd0, 3'd0, 4'd8);      // jr r7
    imem32[8'h0E >> 1] = f_r(3'd7, 3'd0, 3'd4, 4'd0);      // add r4,r7,r0

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_imem_req", 32'(i16_req), 32'd0);
    chk("rst_dmem_req", 32'(d16_req), 32'd0);
    chk("rst_dmem_we", 32'(d16_we), 32'd0);
    chk("rst_retire", 32'(ret16), 32'd0);
    chk("rst_dmem_addr", 32'(d16_addr), 32'd0);
    chk("rst_dmem_wdata", 32'(d16_wdata), 32'd0);
    chk("rst_alu_result", 32'(alu16), 32'd0);
    chk("rst_pc", 32'(pc16), 32'd0);
    chk("rst_cycle_cnt", cyc16, 32'd0);
    chk("rst_instret_cnt", ins16, 32'd0);
    chk("rst32_imem_req", 32'(i32_req), 32'd0);
    chk("rst32_pc", 32'(pc32), 32'd0);

    push16(4,  32'h00, 32'h0005, 1'b1, 0);
    push16(8,  32'h02, 32'hFFFD, 1'b1, 1);
    push16(12, 32'h04, 32'h0002, 1'b1, 2);
    push16(16, 32'h06, 32'h0020, 1'b1, 3);
    push16(19, 32'h08, 32'h0,    1'b0, 4);
    push16(22, 32'h10, 32'h0,    1'b0, 5);
    push16(25, 32'h16, 32'h0,    1'b0, 6);
    push16(28, 32'h20, 32'h0,    1'b0, 7);
    push16(31, 32'h80, 32'h0,    1'b0, 8);
    push16(35, 32'h22, 32'h0030, 1'b1, 9);
    push16(39, 32'h24, 32'h0001, 1'b1, 10);
    push16(42, 32'h26, 32'h0,    1'b0, 11);
    push16(46, 32'h28, 32'h0032, 1'b1, 12);
    push16(50, 32'h2A, 32'h0007, 1'b1, 13);
    push16(54, 32'h2C, 32'h0034, 1'b1, 14);
    push16(64, 32'h2E, 32'h0004, 1'b1, 15);
    push16(68, 32'h30, 32'h0036, 1'b1, 16);
    push_st(16'h0020, 16'h0002);
    push_st(16'h0030, 16'h0022);
    push_st(16'h0032, 16'h0005);
    push_st(16'h0034, 16'h0000);
    push_st(16'h0036, 16'hBEEF);

    push32(4,  32'h00, 32'hFFFF_FFFF, 1'b1, 0);
    push32(8,  32'h02, 32'hFFFF_FFFE, 1'b1, 1);
    push32(12, 32'h04, 32'h0000_0001, 1'b1, 2);
    push32(16, 32'h06, 32'hFFFF_FFFE, 1'b1, 3);
    push32(20, 32'h08, 32'h0000_0001, 1'b1, 4);
    push32(24, 32'h0A, 32'hFFFF_FFFE, 1'b1, 5);
    push32(27, 32'h0C, 32'h0,         1'b0, 6);
    push32(30, 32'h20, 32'h0,         1'b0, 7);
    push32(34, 32'h0E, 32'h0000_000E, 1'b1, 8);

    @(negedge clk);
    reset_n = 1'b1;
    rst32_n = 1'b1;
    t0 = tcyc;

    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (d16_req && d16_we && (d16_addr == 16'h0006)) begin
        found = 1'b1;
        break;
      end
    end
    chk("sw_reset_point_reached", 32'(found), 32'd1);
    chk("ret16_pending", 32'(q16.size()), 32'd0);
    chk("ret32_pending", 32'(q32.size()), 32'd0);
    chk("store_pending", 32'(qst.size()), 32'd0);

    #1 reset_n = 1'b0;
    #1;
    chk("midrst_dmem_req", 32'(d16_req), 32'd0);
    chk("midrst_imem_req", 32'(i16_req), 32'd0);
    chk("midrst_dmem_we", 32'(d16_we), 32'd0);
    chk("midrst_pc", 32'(pc16), 32'd0);
    chk("midrst_alu_result", 32'(alu16), 32'd0);
    chk("midrst_cycle_cnt", cyc16, 32'd0);
    chk("midrst_instret_cnt", ins16, 32'd0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    push16(4, 32'h00, 32'h0005, 1'b1, 0);
    reset_n = 1'b1;
    t0 = tcyc;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (q16.size() == 0) break;
    end
    chk("ret16_after_reset_pending", 32'(q16.size()), 32'd0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("extra_retires", 32'(n_extra16), 32'd0);
    chk("extra_stores", 32'(n_extra_st), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
